// File: rtl/mux_pipe_pkg.sv
// Shared types for the registered 2:1 selector and its skid buffer.
package mux_pipe_pkg;

    localparam int WIDTH = 64;

    typedef logic [WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    // Number of buffer entries held in a given state.
    function automatic int occupancy(input skid_state_e s);
        case (s)
            EMPTY:   return 0;
            ONE:     return 1;
            FULL:    return 2;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/mux_skid_buf.sv
// Two-entry valid/ready skid buffer; head entry drives the registered output.
module mux_skid_buf
    import mux_pipe_pkg::*;
#(
    parameter int DW    = 64,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready
);

    skid_state_e   state_reg, state_next;
    logic [DW-1:0] head_reg, head_next;
    logic [DW-1:0] tail_reg, tail_next;
    logic          in_ready_reg, in_ready_next;
    logic          out_valid_reg, out_valid_next;
    logic          push, pop;

    assign push = in_valid & in_ready_reg;
    assign pop  = out_valid_reg & out_ready;

    always_comb begin
        state_next = state_reg;
        head_next  = head_reg;
        tail_next  = tail_reg;
        case (state_reg)
            EMPTY: begin
                if (push) begin
                    head_next  = in_data;
                    state_next = ONE;
                end
            end
            ONE: begin
                // Push with pop: the new beat becomes the head directly.
                if (push && pop) begin
                    head_next = in_data;
                end else if (push) begin
                    tail_next  = in_data;
                    state_next = FULL;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (pop) begin
                    head_next  = tail_reg;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
        in_ready_next  = occupancy(state_next) < DEPTH;
        out_valid_next = (state_next != EMPTY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= EMPTY;
            head_reg      <= '0;
            tail_reg      <= '0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            head_reg      <= head_next;
            tail_reg      <= tail_next;
            in_ready_reg  <= in_ready_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_data  = head_reg;
    assign out_valid = out_valid_reg;

endmodule

// File: rtl/mux_pipe64.sv
// Registered 2:1 selector with valid/ready output and a combinational copy.
// Define MUX_PIPE_PARITY_EN to add out_parity / out_comb_parity.
module mux_pipe64 #(
    parameter int WIDTH = mux_pipe_pkg::WIDTH,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_0,
    input  logic [WIDTH-1:0] in_1,
    input  logic             sig,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_comb
`ifdef MUX_PIPE_PARITY_EN
    ,
    output logic             out_parity,
    output logic             out_comb_parity
`endif
);

    assign out_comb = sig ? in_1 : in_0;

`ifdef MUX_PIPE_PARITY_EN
    localparam int EW = WIDTH + 1;
    logic [EW-1:0] in_entry, out_entry;

    // Parity travels with its data word through the buffer.
    assign out_comb_parity     = ^out_comb;
    assign in_entry            = {out_comb_parity, out_comb};
    assign {out_parity, out}   = out_entry;
`else
    localparam int EW = WIDTH;
    logic [EW-1:0] in_entry, out_entry;

    assign in_entry = out_comb;
    assign out      = out_entry;
`endif

    mux_skid_buf #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_entry),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_entry),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

endmodule

// File: tb/tb_mux_pipe64.sv
// Directed bench for mux_pipe64: select, latency, backpressure, reset, parity.
module tb_mux_pipe64;
    import mux_pipe_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    data_t in_0, in_1;
    logic  sig, in_valid, out_ready;
    logic  in_ready, out_valid;
    data_t out, out_comb;
`ifdef MUX_PIPE_PARITY_EN
    logic  out_parity, out_comb_parity;
`endif

    int errors = 0;
    int checks = 0;

    localparam data_t ONES = {WIDTH{1'b1}};

    always #5 clk = ~clk;

    mux_pipe64 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_0      (in_0),
        .in_1      (in_1),
        .sig       (sig),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_comb  (out_comb)
`ifdef MUX_PIPE_PARITY_EN
        ,
        .out_parity      (out_parity),
        .out_comb_parity (out_comb_parity)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_0 = 64'h1234; in_1 = ONES; sig = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0;
        #1;
        check("rst_out", out, 64'h0);
        check("rst_valid", {63'b0, out_valid}, 64'h0);
        check("rst_comb", out_comb, 64'h1234);
        step(); step();
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", {63'b0, in_ready}, 64'h1);
        check("post_rst_valid", {63'b0, out_valid}, 64'h0);

        // Basic select and 1-cycle latency
        in_0 = 64'h0; in_1 = ONES; sig = 1'b0; #1;
        check("comb_sel0", out_comb, 64'h0);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        check("out_sel0", out, 64'h0);
        check("valid_sel0", {63'b0, out_valid}, 64'h1);
        sig = 1'b1; #1;
        check("comb_sel1", out_comb, ONES);
        step();
        check("out_sel1", out, ONES);
        check("valid_sel1", {63'b0, out_valid}, 64'h1);
        in_valid = 1'b0;
        step();
        check("drain_valid", {63'b0, out_valid}, 64'h0);

        // Backpressure fills the buffer, then drains in order
        out_ready = 1'b0; sig = 1'b0; in_0 = 64'h1; in_valid = 1'b1;
        step();
        check("bp1_out", out, 64'h1);
        check("bp1_in_ready", {63'b0, in_ready}, 64'h1);
        in_0 = 64'h2;
        step();
        check("bp2_in_ready", {63'b0, in_ready}, 64'h0);
        check("bp2_out", out, 64'h1);
        in_valid = 1'b0; in_0 = 64'h9;
        step();
        check("bp_hold_out", out, 64'h1);
        check("bp_hold_valid", {63'b0, out_valid}, 64'h1);
        out_ready = 1'b1;
        step();
        check("bp_pop1_out", out, 64'h2);
        check("bp_pop1_valid", {63'b0, out_valid}, 64'h1);
        check("bp_pop1_in_ready", {63'b0, in_ready}, 64'h1);
        step();
        check("bp_pop2_valid", {63'b0, out_valid}, 64'h0);

        // Streaming with alternating select, no bubbles
        in_0 = 64'h0; in_1 = ONES; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sig = i[0];
            step();
            check($sformatf("stream%0d_out", i), out, i[0] ? ONES : 64'h0);
            check($sformatf("stream%0d_valid", i), {63'b0, out_valid}, 64'h1);
        end
        in_valid = 1'b0;
        step();

        // Asynchronous reset with the buffer full
        out_ready = 1'b0; sig = 1'b0; in_valid = 1'b1; in_0 = 64'h5;
        step();
        in_0 = 64'h6;
        step();
        check("full_in_ready", {63'b0, in_ready}, 64'h0);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out", out, 64'h0);
        check("async_rst_valid", {63'b0, out_valid}, 64'h0);
        step();
        rst_n = 1'b1; out_ready = 1'b1;
        step();
        check("after_rst_valid", {63'b0, out_valid}, 64'h0);
        check("after_rst_in_ready", {63'b0, in_ready}, 64'h1);
        step();
        check("after_rst_valid2", {63'b0, out_valid}, 64'h0);

`ifdef MUX_PIPE_PARITY_EN
        in_1 = 64'h1; sig = 1'b1; in_valid = 1'b1; out_ready = 1'b1; #1;
        check("comb_parity1", {63'b0, out_comb_parity}, 64'h1);
        step();
        check("out_parity1", {63'b0, out_parity}, 64'h1);
        check("out_par1_data", out, 64'h1);
        in_1 = 64'h3; #1;
        check("comb_parity3", {63'b0, out_comb_parity}, 64'h0);
        step();
        check("out_parity3", {63'b0, out_parity}, 64'h0);
        check("out_par3_data", out, 64'h3);
        in_valid = 1'b0;
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_pipe64.md
Name: mux_pipe64

Overview:
- Registered 2:1 data selector for the 64-bit datapath.
- Chooses `in_0` or `in_1` by `sig` and presents the result on a registered, valid/ready-handshaked output.
- Also provides a pure combinational copy of the selection.
- Sits between operand sources and downstream stages that may stall; a 2-entry skid buffer gives full throughput under backpressure.

Parameters:
- WIDTH, 64, data width of `in_0`, `in_1`, `out`, `out_comb`.
- DEPTH, 2, skid buffer entries; fixed at 2, other values unsupported.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_0  input  WIDTH  data selected when `sig`=0
- in_1  input  WIDTH  data selected when `sig`=1
- sig  input  1  select
- in_valid  input  1  input beat present
- in_ready  output  1  block can accept a beat
- out  output  WIDTH  registered selected data
- out_valid  output  1  `out` holds a valid beat
- out_ready  input  1  downstream accepts `out`
- out_comb  output  WIDTH  combinational selection, no handshake

Behaviour:
- Clocking and reset:
  - One clock domain.
  - Reset is asynchronous and active-low; assert anywhere, deassert synchronously to `clk`.
  - During and after reset: `out`=0, `out_valid`=0, both buffer entries empty, `in_ready`=1 from the first cycle after deassertion.
- `out_comb` = `sig` ? `in_1` : `in_0` at all times, including during reset.
  - If `sig` is X/Z, `out_comb` is X.
- Input transfer:
  - A beat transfers when `in_valid` & `in_ready` at a rising edge.
  - The stored value is the selection made at that edge; later changes to `sig`, `in_0` or `in_1` do not affect stored data.
- Output transfer:
  - A beat leaves when `out_valid` & `out_ready`.
  - `out` and `out_valid` are registered; no combinational path from inputs to them.
  - `out_valid` and `out` hold stable while `out_ready`=0.
- Latency: 1 cycle from accepted input to `out_valid` when empty.
- Throughput: one beat per cycle while `out_ready`=1.
- Skid buffer:
  - `in_ready` is registered: `in_ready`=1 iff fewer than 2 entries are occupied after the current edge's updates.
  - States: EMPTY, ONE, FULL.
  - Transitions:
    - EMPTY + push → ONE.
    - ONE + push, no pop → FULL.
    - ONE + pop, no push → EMPTY.
    - ONE + push + pop → ONE.
    - FULL + pop → ONE.
    - FULL + push is impossible because `in_ready`=0.
  - Order is strictly FIFO; `out` shows the oldest entry.
- Simultaneous push and pop in FULL: impossible. In ONE, the new data replaces the head on the same edge.
- Reset mid-operation: all contents discarded; no beat is emitted after reset.
- `in_valid` may drop without a handshake; no beat is stored.

Optional Feature:
- Macro `MUX_PIPE_PARITY_EN`.
- When defined:
  - Extra output `out_parity` (1 bit) = XOR-reduce of `out`, registered alongside `out` and stored per buffer entry.
  - Extra output `out_comb_parity` = XOR-reduce of `out_comb`.
  - `out_parity` reset value is 0.
- When undefined: neither port exists; all other behaviour is unchanged.

Decomposition:
- Shared package `mux_pipe_pkg`:
  - `WIDTH` default constant (64).
  - `data_t` typedef (logic [WIDTH-1:0]).
  - enum `skid_state_e` {EMPTY, ONE, FULL}.
- One sub-module, `mux_skid_buf`: generic 2-entry valid/ready skid buffer over `data_t` (plus parity bit when enabled).
- Top level holds the combinational select and instantiates the buffer.

Test Plan:
- Reset, then `in_0`=64'h0, `in_1`=64'hFFFF_FFFF_FFFF_FFFF, `sig`=0 → `out_comb`=64'h0 immediately; with `in_valid`=1, `out_ready`=1 → `out`=64'h0, `out_valid`=1 one cycle later.
- Same data, `sig`=1 → `out_comb`=64'hFFFF_FFFF_FFFF_FFFF; next cycle `out`=64'hFFFF_FFFF_FFFF_FFFF.
- `out_ready`=0; push 64'h1 then 64'h2 → `in_ready`=0 after the second push, `out`=64'h1 held. Release `out_ready` → 64'h1, then 64'h2 emitted in order, `in_ready` returns to 1.
- Streaming with alternating `sig` every cycle, `out_ready`=1 → `out` alternates 0/all-ones with no bubbles, 1-cycle latency.
- Assert `rst_n`=0 mid-stream with buffer FULL → `out`=0 and `out_valid`=0 asynchronously; after release, no stale beat appears.
- With `MUX_PIPE_PARITY_EN`, `in_1`=64'h1, `sig`=1 → `out_comb_parity`=1, `out_parity`=1 with `out`; with `in_1`=64'h3 → 0.
